// File: rtl/rpn_pkg.sv
// rpn_pkg: shared opcode constants and FSM state encoding for the RPN stack core.
// Imported by rpn_alu and rpn_stack_core.
// No ports; constants and types only.
package rpn_pkg;

  // Command opcodes carried on cmd_op
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_SWAP = 3'b111;

  // Command sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EXEC = 2'd2
  } state_e;

endpackage

// File: rtl/rpn_alu.sv
// rpn_alu: combinational two-operand ALU for the RPN stack (y = a op b, a = NOS, b = TOS).
// Ports: a/b operands (WIDTH), op (3-bit opcode), y result (WIDTH), c carry/borrow for ADD/SUB.
// Config: RPN_SAT_EN defined -> ADD saturates to all-ones, SUB clamps to zero; otherwise both wrap.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             c
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    // Top bit of the extended difference is the borrow out
    diff = {1'b0, a} - {1'b0, b};
    y    = b;
    c    = 1'b0;
    case (op)
      OP_ADD: begin
        c = sum[WIDTH];
`ifdef RPN_SAT_EN
        y = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        y = sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        c = diff[WIDTH];
`ifdef RPN_SAT_EN
        y = diff[WIDTH] ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
`else
        y = diff[WIDTH-1:0];
`endif
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      default: ;
    endcase
  end

endmodule

// File: rtl/rpn_stack_core.sv
// rpn_stack_core: RPN operand stack, TOS in a register, entries below TOS in a sync-read RAM.
// Ports: CLOCK_50/reset (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_data command handshake;
//        tos, count, empty, full, flag_c, err_ovf, err_unf status. Optional RPN_SAT_EN (saturating ADD/SUB, in rpn_alu).
module rpn_stack_core
  import rpn_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] tos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             flag_c,
  output logic             err_ovf,
  output logic             err_unf
);

  // RAM holds DEPTH-1 entries; keep at least one address bit when DEPTH==2
  localparam int RAM_N = DEPTH - 1;
  localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

  logic [WIDTH-1:0] mem [RAM_N];

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] tos_q,     tos_d;
  logic [CW-1:0]    count_q,   count_d;
  logic             flag_c_q,  flag_c_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;
  logic [2:0]       op_q,      op_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [WIDTH-1:0] rd_data_q;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  logic             accept;
  logic [AW-1:0]    sp_addr;
  logic [AW-1:0]    nos_addr;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;

  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));

  // sp = count-1 is the next free RAM slot; NOS sits one below it.
  // Both wrap when the stack is too shallow, but are only used when valid.
  assign sp_addr  = AW'(count_q - CW'(1));
  assign nos_addr = AW'(count_q - CW'(2));

  assign tos     = tos_q;
  assign count   = count_q;
  assign flag_c  = flag_c_q;
  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

  rpn_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a  (rd_data_q),
    .b  (tos_q),
    .op (op_q),
    .y  (alu_y),
    .c  (alu_c)
  );

  always_comb begin
    state_d   = state_q;
    tos_d     = tos_q;
    count_d   = count_q;
    flag_c_d  = flag_c_q;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    op_d      = op_q;
    rd_addr_d = rd_addr_q;
    mem_we    = 1'b0;
    mem_waddr = sp_addr;
    mem_wdata = tos_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = cmd_op;
          case (cmd_op)
            OP_NOP: begin
              err_ovf_d = 1'b0;
              err_unf_d = 1'b0;
            end
            OP_PUSH: begin
              if (full) begin
                err_ovf_d = 1'b1;
              end else begin
                // Old TOS spills into the RAM only if there was one
                mem_we  = !empty;
                tos_d   = cmd_data;
                count_d = count_q + CW'(1);
              end
            end
            OP_POP: begin
              if (empty) begin
                err_unf_d = 1'b1;
              end else begin
                // A single-entry POP still walks the read path so timing is uniform
                rd_addr_d = nos_addr;
                state_d   = S_RD;
              end
            end
            default: begin
              // SWAP and ALU ops both need two entries
              if (count_q < CW'(2)) begin
                err_unf_d = 1'b1;
              end else begin
                rd_addr_d = nos_addr;
                state_d   = S_RD;
              end
            end
          endcase
        end
      end

      S_RD: begin
        state_d = S_EXEC;
      end

      S_EXEC: begin
        state_d = S_IDLE;
        case (op_q)
          OP_POP: begin
            tos_d   = (count_q == CW'(1)) ? '0 : rd_data_q;
            count_d = count_q - CW'(1);
          end
          OP_SWAP: begin
            mem_we    = 1'b1;
            mem_waddr = nos_addr;
            tos_d     = rd_data_q;
          end
          default: begin
            tos_d   = alu_y;
            count_d = count_q - CW'(1);
            if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
              flag_c_d = alu_c;
            end
          end
        endcase
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tos_q     <= '0;
      count_q   <= '0;
      flag_c_q  <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      op_q      <= OP_NOP;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      tos_q     <= tos_d;
      count_q   <= count_d;
      flag_c_q  <= flag_c_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
      op_q      <= op_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Stack RAM: one write port, registered read; contents are not reset.
  // Writes never coincide with the S_RD read cycle, so no bypass is needed.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_data_q <= mem[rd_addr_q];
  end

endmodule

// File: tb/tb_rpn_stack_core.sv
// tb_rpn_stack_core: directed-vector bench for rpn_stack_core (WIDTH=8, DEPTH=4).
// Driver queues the expected post-command state; a negedge monitor pops and compares
// whenever a command completes (cmd_ready high again after an accept).
`timescale 1ns/1ps
module tb_rpn_stack_core;
  import rpn_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

`ifdef RPN_SAT_EN
  localparam logic [7:0] SUB_NEG = 8'h00;
  localparam logic [7:0] ADD_OV  = 8'hFF;
  localparam logic [7:0] AND_R   = 8'h0F;
`else
  localparam logic [7:0] SUB_NEG = 8'hFE;
  localparam logic [7:0] ADD_OV  = 8'd44;
  localparam logic [7:0] AND_R   = 8'h0C;
`endif

  logic         CLOCK_50  = 1'b0;
  logic         reset     = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op    = OP_NOP;
  logic [W-1:0] cmd_data  = '0;
  logic [W-1:0] tos;
  logic [2:0]   count;
  logic         empty, full, flag_c, err_ovf, err_unf;

  rpn_stack_core #(.WIDTH(W), .DEPTH(D)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .tos       (tos),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .flag_c    (flag_c),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [7:0] tos;
    logic [2:0] cnt;
    logic       fc;
    logic       ovf;
    logic       unf;
    int         busy;   // cycles cmd_ready is low; negative = don't care
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, expv);
    end
  endtask

  task automatic expect_state(input logic [7:0] etos, input int ecnt, input logic efc,
                              input logic eovf, input logic eunf, input int ebusy, input string nm);
    exp_t e;
    e.tos = etos; e.cnt = 3'(ecnt); e.fc = efc; e.ovf = eovf; e.unf = eunf; e.busy = ebusy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge CLOCK_50);
    while (!cmd_ready && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (!cmd_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: cmd_ready stayed 0 for %0d cycles, expected 1", n);
    end
  endtask

  // Issue one command; returns one ns after its accept edge
  task automatic send(input logic [2:0] op, input logic [7:0] d, input logic [7:0] etos,
                      input int ecnt, input logic efc, input logic eovf, input logic eunf,
                      input int ebusy, input string nm);
    expect_state(etos, ecnt, efc, eovf, eunf, ebusy, nm);
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    wait_ready();
    @(posedge CLOCK_50);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Monitor: an accept is seen at the negedge before its edge; the result is
  // compared at the first later negedge where cmd_ready is high again.
  initial begin
    bit pending;
    int busy;
    exp_t e;
    string nm;
    bit ok;
    pending = 1'b0;
    busy    = 0;
    forever begin
      @(negedge CLOCK_50);
      if (pending) begin
        if (cmd_ready) begin
          pending = 1'b0;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_result: tos=%0h count=%0d, expected no result", tos, count);
          end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            ok = (tos === e.tos) && (count === e.cnt) && (flag_c === e.fc) &&
                 (err_ovf === e.ovf) && (err_unf === e.unf) &&
                 (empty === (e.cnt == 3'd0)) && (full === (e.cnt == 3'(D))) &&
                 ((e.busy < 0) || (busy == e.busy));
            if (!ok) begin
              miscompares++;
              $display("FAIL %s: got tos=%0h cnt=%0d c=%0b ovf=%0b unf=%0b empty=%0b full=%0b busy=%0d, expected tos=%0h cnt=%0d c=%0b ovf=%0b unf=%0b busy=%0d",
                       nm, tos, count, flag_c, err_ovf, err_unf, empty, full, busy,
                       e.tos, e.cnt, e.fc, e.ovf, e.unf, e.busy);
            end
          end
        end else begin
          busy++;
        end
      end
      if (cmd_valid && cmd_ready) begin
        pending = 1'b1;
        busy    = 0;
      end
    end
  end

  initial begin
    int n;
    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("ready_in_reset", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_tos",   32'(tos),       32'd0);
    chk("rst_count", 32'(count),     32'd0);
    chk("rst_empty", 32'(empty),     32'd1);
    chk("rst_full",  32'(full),      32'd0);
    chk("rst_flags", 32'({flag_c, err_ovf, err_unf}), 32'd0);
    @(posedge CLOCK_50);
    #1;

    // 5 - 3
    send(OP_PUSH, 8'd5,   8'd5,    1, 1'b0, 1'b0, 1'b0, 0, "push5");
    send(OP_PUSH, 8'd3,   8'd3,    2, 1'b0, 1'b0, 1'b0, 0, "push3");
    send(OP_SUB,  8'd0,   8'd2,    1, 1'b0, 1'b0, 1'b0, 2, "sub_5_3");
    // 3 - 5 borrows
    send(OP_PUSH, 8'd3,   8'd3,    2, 1'b0, 1'b0, 1'b0, 0, "push3b");
    send(OP_PUSH, 8'd5,   8'd5,    3, 1'b0, 1'b0, 1'b0, 0, "push5b");
    send(OP_SUB,  8'd0,   SUB_NEG, 2, 1'b1, 1'b0, 1'b0, 2, "sub_borrow");
    send(OP_POP,  8'd0,   8'd2,    1, 1'b1, 1'b0, 1'b0, 2, "pop_to_2");
    send(OP_POP,  8'd0,   8'd0,    0, 1'b1, 1'b0, 1'b0, 2, "pop_last");
    // 200 + 100 carries, then AND leaves flag_c alone
    send(OP_PUSH, 8'd200, 8'd200,  1, 1'b1, 1'b0, 1'b0, 0, "push200");
    send(OP_PUSH, 8'd100, 8'd100,  2, 1'b1, 1'b0, 1'b0, 0, "push100");
    send(OP_ADD,  8'd0,   ADD_OV,  1, 1'b1, 1'b0, 1'b0, 2, "add_carry");
    send(OP_PUSH, 8'h0F,  8'h0F,   2, 1'b1, 1'b0, 1'b0, 0, "push0f");
    send(OP_AND,  8'd0,   AND_R,   1, 1'b1, 1'b0, 1'b0, 2, "and");
    send(OP_POP,  8'd0,   8'd0,    0, 1'b1, 1'b0, 1'b0, 2, "pop_and");
    // Fill, overflow, clear, unwind
    send(OP_PUSH, 8'd1,   8'd1,    1, 1'b1, 1'b0, 1'b0, 0, "fill1");
    send(OP_PUSH, 8'd2,   8'd2,    2, 1'b1, 1'b0, 1'b0, 0, "fill2");
    send(OP_PUSH, 8'd3,   8'd3,    3, 1'b1, 1'b0, 1'b0, 0, "fill3");
    send(OP_PUSH, 8'd4,   8'd4,    4, 1'b1, 1'b0, 1'b0, 0, "fill4_full");
    send(OP_PUSH, 8'd9,   8'd4,    4, 1'b1, 1'b1, 1'b0, 0, "push_ovf");
    send(OP_NOP,  8'd0,   8'd4,    4, 1'b1, 1'b0, 1'b0, 0, "nop_clr_ovf");
    send(OP_POP,  8'd0,   8'd3,    3, 1'b1, 1'b0, 1'b0, 2, "unwind3");
    send(OP_POP,  8'd0,   8'd2,    2, 1'b1, 1'b0, 1'b0, 2, "unwind2");
    send(OP_POP,  8'd0,   8'd1,    1, 1'b1, 1'b0, 1'b0, 2, "unwind1");
    send(OP_POP,  8'd0,   8'd0,    0, 1'b1, 1'b0, 1'b0, 2, "unwind0");
    // Underflow cases
    send(OP_PUSH, 8'd7,   8'd7,    1, 1'b1, 1'b0, 1'b0, 0, "push7");
    send(OP_ADD,  8'd0,   8'd7,    1, 1'b1, 1'b0, 1'b1, 0, "add_unf");
    send(OP_POP,  8'd0,   8'd0,    0, 1'b1, 1'b0, 1'b1, 2, "pop_after_unf");
    send(OP_POP,  8'd0,   8'd0,    0, 1'b1, 1'b0, 1'b1, 0, "pop_empty_unf");
    send(OP_NOP,  8'd0,   8'd0,    0, 1'b1, 1'b0, 1'b0, 0, "nop_clr_unf");
    send(OP_PUSH, 8'd1,   8'd1,    1, 1'b1, 1'b0, 1'b0, 0, "push1_swap");
    send(OP_SWAP, 8'd0,   8'd1,    1, 1'b1, 1'b0, 1'b1, 0, "swap_unf");
    send(OP_NOP,  8'd0,   8'd1,    1, 1'b1, 1'b0, 1'b0, 0, "nop_clr2");
    // SWAP, OR
    send(OP_PUSH, 8'd2,   8'd2,    2, 1'b1, 1'b0, 1'b0, 0, "push2_swap");
    send(OP_SWAP, 8'd0,   8'd1,    2, 1'b1, 1'b0, 1'b0, 2, "swap");
    send(OP_POP,  8'd0,   8'd2,    1, 1'b1, 1'b0, 1'b0, 2, "pop_swapped");
    send(OP_PUSH, 8'h50,  8'h50,   2, 1'b1, 1'b0, 1'b0, 0, "push50");
    send(OP_OR,   8'd0,   8'h52,   1, 1'b1, 1'b0, 1'b0, 2, "or");
    send(OP_PUSH, 8'd6,   8'd6,    2, 1'b1, 1'b0, 1'b0, 0, "push6");

    // POP aborted by reset while in S_RD
    expect_state(8'd0, 0, 1'b0, 1'b0, 1'b0, -1, "pop_reset_abort");
    cmd_op    = OP_POP;
    cmd_data  = '0;
    cmd_valid = 1'b1;
    wait_ready();
    @(posedge CLOCK_50);
    #1;
    cmd_valid = 1'b0;
    reset     = 1'b1;
    @(posedge CLOCK_50);
    #1;
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk("ready_after_release", 32'(cmd_ready), 32'd1);
    @(posedge CLOCK_50);
    #1;
    send(OP_PUSH, 8'h33,  8'h33,   1, 1'b0, 1'b0, 1'b0, 0, "push_after_reset");

    // Drain the scoreboard
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    @(negedge CLOCK_50);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rpn_stack_core.md
# rpn_stack_core

Parametrised RPN calculator datapath. It holds a hardware operand stack of DEPTH entries × WIDTH bits, with the top of stack (TOS) kept in a register and the rest in an inferred synchronous-read RAM. Commands arrive through a valid/ready handshake: push, pop, swap, nop, or a binary ALU operation on the top two entries. The board top level drives it from switches and keys and shows `tos` and status on LEDs and seven-segment displays.

## Interface
- WIDTH, 8, operand/data width in bits (≥2)
- DEPTH, 16, maximum stack entries including TOS (≥2); the RAM holds DEPTH-1 entries
- CLOCK_50  in  1  single system clock, all logic on posedge
- reset  in  1  synchronous, active-high; clears all state
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept; high only in S_IDLE and with reset low
- cmd_op  in  3  000 NOP, 001 PUSH, 010 POP, 011 ADD, 100 SUB, 101 AND, 110 OR, 111 SWAP
- cmd_data  in  WIDTH  operand for PUSH, ignored otherwise
- tos  out  WIDTH  top-of-stack register, 0 when empty
- count  out  $clog2(DEPTH+1)  number of valid entries
- empty  out  1  count==0
- full  out  1  count==DEPTH
- flag_c  out  1  carry (ADD) / borrow (SUB) of the last ADD/SUB executed
- err_ovf  out  1  sticky: PUSH attempted when full
- err_unf  out  1  sticky: POP/SWAP/ALU attempted with too few entries

## Operation
- Accept is `cmd_valid && cmd_ready` at a rising edge. Op and data are captured at that edge.
- Internal RAM pointer `sp = count-1` when count>0. Below-TOS entries live at mem[0..sp-1]. NOS is mem[sp-1].
- FSM states: S_IDLE, S_RD, S_EXEC.
- **PUSH** (count<DEPTH): executes at the accept edge.
  - If count>0, mem[sp] <= tos.
  - tos <= cmd_data; count++.
  - Stays in S_IDLE.
- **NOP**: clears err_ovf and err_unf; no other effect; stays in S_IDLE.
- **POP, SWAP, ADD/SUB/AND/OR**: at the accept edge, the RAM read address is set to sp-1 and the FSM moves to S_RD. It then moves to S_EXEC, where NOS is valid.
- Effect at the S_EXEC edge, after which the FSM returns to S_IDLE:
  - POP: tos <= NOS, count--. If count was 1, no read is used, tos <= 0, count <= 0, and the same state path is still taken.
  - SWAP: mem[sp-1] <= tos; tos <= NOS; count unchanged.
  - ALU ops: tos <= NOS op TOS; count--.
- Operand order: push a, push b, SUB gives a−b.
- All arithmetic is unsigned and modulo 2^WIDTH.
  - flag_c = carry-out for ADD, borrow for SUB.
  - AND/OR leave flag_c unchanged.
- Error checks at accept:
  - PUSH when full sets err_ovf.
  - POP with count==0 sets err_unf.
  - SWAP/ALU with count<2 sets err_unf.
  - An erroring command is consumed with no stack or tos change, and the FSM stays in S_IDLE.
- Error flags stay set until a NOP or reset.

## Timing
- Reset values: tos=0, count=0, empty=1, full=0, flag_c=0, err_ovf=0, err_unf=0, FSM=S_IDLE. cmd_ready is 0 while reset is high. RAM contents are not reset.
- PUSH, NOP and erroring commands: one per cycle; cmd_ready stays high.
- POP/SWAP/ALU: cmd_ready is low for exactly 2 cycles (S_RD, S_EXEC). Results are visible on tos/count the cycle after the S_EXEC edge. The next accept can happen at edge T0+3.
- Reset in S_RD or S_EXEC aborts the command with no partial update. cmd_ready is high the first cycle after reset is released.
- Outputs are registered, except empty, full and cmd_ready, which are decoded from registers.

## Configuration
- RPN_SAT_EN defined: ADD saturates to all-ones on carry, and SUB clamps to 0 on borrow. flag_c still reports the carry/borrow.
- RPN_SAT_EN undefined: ADD and SUB wrap modulo 2^WIDTH.

## Structure
- Package rpn_pkg holds:
  - opcode constants (OP_NOP … OP_SWAP)
  - FSM state encodings (S_IDLE, S_RD, S_EXEC)
- Sub-module rpn_alu:
  - combinational, parameter WIDTH
  - inputs a (NOS), b (TOS), op
  - outputs y, c
  - contains the RPN_SAT_EN logic
- The stack RAM is inferred inside rpn_stack_core.

## Test plan
All scenarios use WIDTH=8, DEPTH=4.
- Reset; PUSH 5, PUSH 3, SUB -> tos=2, count=1, flag_c=0; cmd_ready low exactly 2 cycles.
- PUSH 3, PUSH 5, SUB -> tos=0xFE, flag_c=1 (RPN_SAT_EN: tos=0x00, flag_c=1).
- PUSH 200, PUSH 100, ADD -> tos=44, flag_c=1 (RPN_SAT_EN: tos=255); then PUSH 0x0F, AND -> tos=0x0C (RPN_SAT_EN: 0x0F), flag_c unchanged.
- PUSH 1,2,3,4 back-to-back -> full=1, tos=4; PUSH 9 -> err_ovf=1, tos=4, count=4; NOP -> err_ovf=0; POP ×3 -> tos 3,2,1.
- Empty; PUSH 7, ADD -> err_unf=1, tos=7, count=1; POP -> tos=0, empty=1; POP -> err_unf stays 1, count=0.
- PUSH 1, PUSH 2, SWAP -> tos=1, count=2; POP -> tos=2; PUSH 6, POP with reset asserted during S_RD -> count=0, tos=0, err flags 0, cmd_ready=1 one cycle after release.
